// File: rtl/ps2_key_tracker_if.sv
// Byte-stream input and per-key status bundle between a PS/2 receiver and the key tracker.
interface ps2_key_tracker_if #(
   parameter int unsigned NUM_KEYS = 5
) ();
   logic                rx_done_tick;
   logic [7:0]          rx_dout;
   logic                clear_all;
   logic [NUM_KEYS-1:0] key_held;
   logic [NUM_KEYS-1:0] key_press;
   logic [NUM_KEYS-1:0] key_rel;
   logic                any_held;
   logic                err_tick;

   modport master (
      output rx_done_tick, rx_dout, clear_all,
      input  key_held, key_press, key_rel, any_held, err_tick
   );

   modport slave (
      input  rx_done_tick, rx_dout, clear_all,
      output key_held, key_press, key_rel, any_held, err_tick
   );
endinterface

// File: rtl/ps2_key_tracker.sv
// Decodes PS/2 set-2 make/break sequences (with E0 extension) into held/press/release
// state for a configurable set of keys, with a prefix-state idle timeout.
module ps2_key_tracker #(
   parameter int unsigned                NUM_KEYS       = 5,
   parameter logic [NUM_KEYS*8-1:0]      KEY_CODES      = {8'h5A, 8'h2B, 8'h23, 8'h1B, 8'h1C},
   parameter logic [NUM_KEYS-1:0]        KEY_EXT        = '0,
   parameter int unsigned                TIMEOUT_CYCLES = 2000000
) (
   input  logic               clk,
   input  logic               reset,
   ps2_key_tracker_if.slave   bus
);
   localparam int unsigned CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam logic [CW-1:0] TO_MAX = CW'(TIMEOUT_CYCLES);

   typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} state_t;

   state_t              state, state_nxt;
   logic [CW-1:0]       cnt, cnt_nxt;
   logic                do_make, do_break, ext, err_nxt, ignored;
   logic [NUM_KEYS-1:0] match, set_vec, clr_vec;
   logic [NUM_KEYS-1:0] held, press, rel;
   logic                any, err;

   // Host/ack bytes that never belong to a key sequence
   always_comb begin
      ignored = 1'b0;
      case (bus.rx_dout)
         8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFE, 8'hFF: ignored = 1'b1;
         default: ignored = 1'b0;
      endcase
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      do_make   = 1'b0;
      do_break  = 1'b0;
      ext       = 1'b0;
      err_nxt   = 1'b0;
      if (bus.clear_all) begin
         state_nxt = IDLE;
         cnt_nxt   = '0;
      end else if (bus.rx_done_tick) begin
         cnt_nxt = '0;
         if (ignored) begin
            state_nxt = IDLE;
         end else begin
            case (state)
               IDLE: begin
                  if (bus.rx_dout == 8'hE0)      state_nxt = EXT;
                  else if (bus.rx_dout == 8'hF0) state_nxt = BRK;
                  else                           do_make   = 1'b1;
               end
               EXT: begin
                  if (bus.rx_dout == 8'hF0)      state_nxt = EXT_BRK;
                  else if (bus.rx_dout == 8'hE0) state_nxt = EXT;
                  else begin
                     do_make   = 1'b1;
                     ext       = 1'b1;
                     state_nxt = IDLE;
                  end
               end
               default: begin
                  // A prefix inside a break sequence is malformed; restart decoding from it
                  if (bus.rx_dout == 8'hE0) begin
                     err_nxt   = 1'b1;
                     state_nxt = EXT;
                  end else if (bus.rx_dout == 8'hF0) begin
                     err_nxt   = 1'b1;
                     state_nxt = BRK;
                  end else begin
                     do_break  = 1'b1;
                     ext       = (state == EXT_BRK);
                     state_nxt = IDLE;
                  end
               end
            endcase
         end
      end else if (state != IDLE) begin
         if (cnt >= TO_MAX) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
            err_nxt   = 1'b1;
         end else begin
            cnt_nxt = cnt + CW'(1);
         end
      end else begin
         cnt_nxt = '0;
      end
   end

   always_comb begin
      for (int i = 0; i < NUM_KEYS; i++) begin
         match[i] = (KEY_CODES[8*i +: 8] == bus.rx_dout) && (KEY_EXT[i] == ext);
      end
      set_vec = do_make  ? (match & ~held) : '0;
      clr_vec = do_break ? (match &  held) : '0;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // Key status; any_held trails key_held by one cycle
   always_ff @(posedge clk) begin
      if (reset) begin
         held  <= '0;
         press <= '0;
         rel   <= '0;
         any   <= 1'b0;
         err   <= 1'b0;
      end else begin
         any <= |held;
         err <= err_nxt;
         if (bus.clear_all) begin
            held  <= '0;
            press <= '0;
            rel   <= '0;
         end else begin
            held  <= (held | set_vec) & ~clr_vec;
            press <= set_vec;
            rel   <= clr_vec;
         end
      end
   end

   assign bus.key_held  = held;
   assign bus.key_press = press;
   assign bus.key_rel   = rel;
   assign bus.any_held  = any;
   assign bus.err_tick  = err;
endmodule

// File: tb/tb_ps2_key_tracker.sv
// Self-checking bench for ps2_key_tracker: random byte streams against a prefix-flag key model,
// followed by directed make/break, typematic, extended, timeout, clear and reset scenarios.
module tb_ps2_key_tracker;
   localparam int unsigned NK = 5;
   localparam int unsigned TO = 20;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   ps2_key_tracker_if #(.NUM_KEYS(NK)) bus ();

   ps2_key_tracker #(
      .NUM_KEYS       (NK),
      .KEY_CODES      ({8'h5A, 8'h2B, 8'h23, 8'h1B, 8'h1C}),
      .KEY_EXT        (5'b10000),
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   logic [7:0] codes [NK] = '{8'h1C, 8'h1B, 8'h23, 8'h2B, 8'h5A};
   logic [NK-1:0] ext_mask = 5'b10000;
   logic [7:0] ign [7] = '{8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFE, 8'hFF};

   logic [NK-1:0] held_m;
   bit e0_m, f0_m;
   int npass = 0, ntotal = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      ntotal++;
      assert (obs === exp) npass++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   function automatic bit is_ign(input logic [7:0] b);
      for (int i = 0; i < 7; i++) if (ign[i] == b) return 1'b1;
      return 1'b0;
   endfunction

   // Model: prefix flags describe what has been seen; a key byte completes the sequence
   task automatic model(input logic [7:0] b, input bit clr,
                        output logic [NK-1:0] ep, output logic [NK-1:0] er, output bit ee);
      ep = '0; er = '0; ee = 1'b0;
      if (clr) begin
         held_m = '0; e0_m = 0; f0_m = 0;
      end else if (is_ign(b)) begin
         e0_m = 0; f0_m = 0;
      end else if (b == 8'hE0) begin
         ee = f0_m; e0_m = 1; f0_m = 0;
      end else if (b == 8'hF0) begin
         ee = f0_m;
         if (f0_m) e0_m = 0;
         f0_m = 1;
      end else begin
         for (int i = 0; i < NK; i++) begin
            if (codes[i] == b && ext_mask[i] == e0_m) begin
               if (f0_m && held_m[i])       er[i] = 1'b1;
               else if (!f0_m && !held_m[i]) ep[i] = 1'b1;
            end
         end
         held_m = (held_m | ep) & ~er;
         e0_m = 0; f0_m = 0;
      end
   endtask

   task automatic send(input logic [7:0] b, input bit clr);
      logic [NK-1:0] ep, er;
      bit ee;
      model(b, clr, ep, er, ee);
      @(negedge clk);
      bus.rx_dout = b; bus.rx_done_tick = 1'b1; bus.clear_all = clr;
      @(posedge clk); #1;
      chk("press", 32'(bus.key_press), 32'(ep));
      chk("rel",   32'(bus.key_rel),   32'(er));
      chk("held",  32'(bus.key_held),  32'(held_m));
      chk("err",   32'(bus.err_tick),  32'(ee));
      @(negedge clk);
      bus.rx_done_tick = 1'b0; bus.clear_all = 1'b0;
      @(posedge clk); #1;
      chk("press_pulse", 32'(bus.key_press), 32'd0);
      chk("rel_pulse",   32'(bus.key_rel),   32'd0);
      chk("any_held",    32'(bus.any_held),  32'(|held_m));
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      held_m = '0; e0_m = 0; f0_m = 0;
   endtask

   initial begin
      int nerr;
      reset = 1'b1;
      bus.rx_done_tick = 1'b0; bus.rx_dout = 8'h00; bus.clear_all = 1'b0;
      held_m = '0; e0_m = 0; f0_m = 0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(posedge clk); #1;
      chk("rst_held",  32'(bus.key_held),  32'd0);
      chk("rst_press", 32'(bus.key_press), 32'd0);
      chk("rst_rel",   32'(bus.key_rel),   32'd0);
      chk("rst_any",   32'(bus.any_held),  32'd0);
      chk("rst_err",   32'(bus.err_tick),  32'd0);

      // Random byte stream biased toward tracked codes and prefixes
      for (int n = 0; n < 300; n++) begin
         logic [7:0] b;
         int unsigned r = $urandom_range(0, 9);
         if (r <= 3 || r >= 8) b = codes[$urandom_range(0, NK - 1)];
         else if (r == 4)      b = 8'hE0;
         else if (r == 5)      b = 8'hF0;
         else if (r == 6)      b = ign[$urandom_range(0, 6)];
         else                  b = 8'($urandom);
         send(b, $urandom_range(0, 39) == 0);
      end

      // Make, break, then release
      do_reset();
      send(8'h1C, 0); send(8'hF0, 0); send(8'h1C, 0);
      chk("mb_held0", 32'(bus.key_held[0]), 32'd0);
      // Typematic repeat
      send(8'h1C, 0); send(8'h1C, 0); send(8'h1C, 0);
      chk("typ_held0", 32'(bus.key_held[0]), 32'd1);
      // Extended slot 4 ignores plain 5A
      do_reset();
      send(8'h5A, 0);
      chk("ext_plain", 32'(bus.key_held[4]), 32'd0);
      send(8'hE0, 0); send(8'h5A, 0);
      chk("ext_make", 32'(bus.key_held[4]), 32'd1);
      send(8'hE0, 0); send(8'hF0, 0); send(8'h5A, 0);
      chk("ext_break", 32'(bus.key_held[4]), 32'd0);
      // Malformed prefix: F0 then E0
      send(8'hF0, 0); send(8'hE0, 0); send(8'h5A, 0);

      // Prefix timeout
      send(8'hF0, 0);
      nerr = 0;
      for (int c = 0; c < int'(TO) - 2; c++) begin
         @(posedge clk); #1;
         if (bus.err_tick) nerr++;
      end
      chk("to_early", 32'(nerr), 32'd0);
      for (int c = 0; c < 5; c++) begin
         @(posedge clk); #1;
         if (bus.err_tick) nerr++;
      end
      chk("to_pulse", 32'(nerr), 32'd1);
      e0_m = 0; f0_m = 0;
      send(8'h23, 0);
      chk("to_make2", 32'(bus.key_held[2]), 32'd1);

      // clear_all wins over a simultaneous byte
      do_reset();
      send(8'h1C, 0); send(8'h1B, 0);
      send(8'h23, 1);
      chk("clr_held", 32'(bus.key_held), 32'd0);

      // Ignored bytes drop the pending prefix
      send(8'hFA, 0); send(8'hAA, 0); send(8'hF0, 0); send(8'hFE, 0); send(8'h1B, 0);
      chk("ign_make1", 32'(bus.key_held[1]), 32'd1);

      // Reset mid-sequence discards the F0
      send(8'hF0, 0);
      do_reset();
      send(8'h1C, 0);
      chk("rst_mid", 32'(bus.key_held[0]), 32'd1);

      $display("%0d/%0d checks passed", npass, ntotal);
      $finish;
   end
endmodule

// File: doc/ps2_key_tracker.md
PS2_KEY_TRACKER -- requirements
Module: ps2_key_tracker

Interface
REQ-001 Parameter NUM_KEYS, default 5: number of tracked keys, legal range 1..32.
REQ-002 Parameter KEY_CODES, default {8'h5A,8'h2B,8'h23,8'h1B,8'h1C}: NUM_KEYS*8-bit packed set-2 codes; slot i is bits [8i+7:8i], so slot 0 = 8'h1C.
REQ-003 Parameter KEY_EXT, default 0: NUM_KEYS-bit mask; bit i=1 means slot i is an E0-extended key.
REQ-004 Parameter TIMEOUT_CYCLES, default 2000000: maximum idle cycles allowed inside a prefix state.
REQ-005 clk  input  1  system clock; single clock domain.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 rx_done_tick  input  1  one-cycle strobe; rx_dout is valid in that cycle.
REQ-008 rx_dout  input  8  received scan-code byte.
REQ-009 clear_all  input  1  synchronous flush of all key state.
REQ-010 key_held  output  NUM_KEYS  level; bit i=1 while slot i is down.
REQ-011 key_press  output  NUM_KEYS  one-cycle pulse on the up-to-down transition of slot i.
REQ-012 key_rel  output  NUM_KEYS  one-cycle pulse on the down-to-up transition of slot i.
REQ-013 any_held  output  1  OR-reduction of key_held, registered.
REQ-014 err_tick  output  1  one-cycle pulse on prefix timeout or malformed prefix sequence.

Function
REQ-015 The decoder SHALL be an FSM with states IDLE, EXT (E0 seen), BRK (F0 seen) and EXT_BRK (E0 F0 seen); it advances only in cycles where rx_done_tick=1.
REQ-016 IDLE: E0 -> EXT; F0 -> BRK; any other non-ignored byte c -> make(c, ext=0), stay in IDLE.
REQ-017 EXT: F0 -> EXT_BRK; E0 -> stay in EXT; any other byte c -> make(c, ext=1), go to IDLE.
REQ-018 BRK: non-prefix byte c -> break(c, ext=0), go to IDLE; EXT_BRK: non-prefix byte c -> break(c, ext=1), go to IDLE.
REQ-019 An E0 or F0 received in BRK or EXT_BRK SHALL pulse err_tick and be decoded exactly as it would be from IDLE.
REQ-020 Bytes 8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFE and 8'hFF SHALL be ignored in every state, with the FSM forced to IDLE and no key effect.
REQ-021 make(c,e): every slot i with KEY_CODES[i]==c and KEY_EXT[i]==e and key_held[i]=0 SHALL set key_held[i]=1 and pulse key_press[i]; a slot already held (typematic repeat) SHALL see no change and no pulse.
REQ-022 break(c,e): every matching slot with key_held[i]=1 SHALL clear key_held[i] and pulse key_rel[i]; a break on a slot not held SHALL have no effect.
REQ-023 Duplicate codes in KEY_CODES SHALL all update together; unmatched codes SHALL only return the FSM to its next state.
REQ-024 Latency: key_held, key_press and key_rel SHALL update in the cycle after the rx_done_tick that completes the sequence; any_held SHALL follow key_held by one further cycle.
REQ-025 A timeout counter SHALL clear on every rx_done_tick and hold at 0 in IDLE; when it reaches TIMEOUT_CYCLES in a non-IDLE state, the FSM SHALL return to IDLE with one err_tick pulse.
REQ-026 The counter SHALL be $clog2(TIMEOUT_CYCLES+1) bits wide and SHALL saturate, never wrap.
REQ-027 clear_all=1 SHALL zero key_held, force the FSM to IDLE, clear the counter and suppress key_rel pulses; any rx_done_tick in that same cycle SHALL be discarded.
REQ-028 Priority order: reset > clear_all > rx_done_tick > timeout.

Reset
REQ-029 Reset SHALL set FSM=IDLE, counter=0 and key_held, key_press, key_rel, any_held and err_tick all to 0.
REQ-030 Reset asserted mid-sequence (e.g. after F0) SHALL discard the partial sequence; the next byte SHALL be decoded from IDLE.

Verification
REQ-031 Bytes 1C, F0, 1C -> key_press[0] pulses once after the first byte, key_held[0] goes 1 then 0, key_rel[0] pulses once after the third byte.
REQ-032 Bytes 1C, 1C, 1C (typematic repeat) -> exactly one key_press[0] pulse; key_held[0] stays 1.
REQ-033 KEY_EXT[4]=1 with KEY_CODES[4]=5A; bytes 5A -> no slot-4 change; bytes E0, 5A, E0, F0, 5A -> slot 4 press then release pulse.
REQ-034 Byte F0, then no byte for TIMEOUT_CYCLES cycles -> one err_tick pulse, FSM in IDLE; next byte 23 -> key_press[2] pulses.
REQ-035 Slots 0 and 1 held, then clear_all plus a simultaneous rx_done_tick with byte 23 -> key_held=0, no key_rel pulses, no key_press[2].
REQ-036 Bytes FA, AA, F0, FE, then 1B -> no key change; 1B is decoded as a make with key_press[1] pulse.
